// File: rtl/alu_tx_sequencer.sv
// Runs one ALU op per start strobe, then writes the result as signed ASCII decimal plus CR/LF to the TX FIFO.
// First write 1+NBIT cycles after the start; each emit state waits on FIFO_full with nothing lost or repeated.
module alu_tx_sequencer #(
   parameter int NBIT   = 8,
   parameter bit SIGNED = 1'b1
) (
   input  logic            CLK,
   input  logic            RESET,
   input  logic [NBIT-1:0] data_in,
   input  logic [2:0]      SEL,
   output logic [NBIT-1:0] ALU_A,
   output logic [NBIT-1:0] ALU_B,
   output logic [NBIT-1:0] ALU_OP,
   input  logic [NBIT-1:0] ALU_RES,
   input  logic            FIFO_full,
   output logic            WR_FIFO,
   output logic [7:0]      tx_data,
   output logic            BUSY,
   output logic            DROP
);

   typedef enum logic [2:0] {IDLE, CALC, CONV, SIGN, DIGITS, CR, LF} state_t;

   localparam logic [NBIT-1:0] OP_RST = NBIT'(8'h20);

   state_t          state;
   logic [NBIT-1:0] bin;
   logic [19:0]     bcd;
   logic [19:0]     bcd_nxt;
   logic            neg;
   logic [2:0]      idx;
   logic [4:0]      cnt;
   logic [NBIT-1:0] mag;
   logic [3:0]      digit;
   logic            emit;
   logic [7:0]      char;

   // One double-dabble step: correct every digit >= 5, then shift the next binary bit in.
   function automatic logic [19:0] dabble(input logic [19:0] b, input logic bit_in);
      logic [19:0] t;
      t = b;
      for (int i = 0; i < 5; i++)
         if (t[i*4 +: 4] >= 4'd5) t[i*4 +: 4] = t[i*4 +: 4] + 4'd3;
      return {t[18:0], bit_in};
   endfunction

   function automatic logic [2:0] lead(input logic [19:0] b);
      logic [2:0] r;
      r = 3'd0;
      for (int i = 0; i < 5; i++)
         if (b[i*4 +: 4] != 4'd0) r = 3'(i);
      return r;
   endfunction

   assign bcd_nxt = dabble(bcd, bin[NBIT-1]);
   // Negating the most negative value wraps to itself, which read unsigned is 2^(NBIT-1).
   assign mag     = (SIGNED && ALU_RES[NBIT-1]) ? -ALU_RES : ALU_RES;
   assign digit   = bcd[{idx, 2'b00} +: 4];

   always_comb begin
      emit = 1'b0;
      char = 8'h00;
      case (state)
         SIGN:    begin emit = 1'b1; char = 8'h2D; end
         DIGITS:  begin emit = 1'b1; char = {4'h3, digit}; end
         CR:      begin emit = 1'b1; char = 8'h0D; end
         LF:      begin emit = 1'b1; char = 8'h0A; end
         default: begin emit = 1'b0; char = 8'h00; end
      endcase
   end

   assign WR_FIFO = emit && !FIFO_full;
   assign tx_data = char;
   assign BUSY    = (state != IDLE);

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state  <= IDLE;
         ALU_A  <= '0;
         ALU_B  <= '0;
         ALU_OP <= OP_RST;
         DROP   <= 1'b0;
         bin    <= '0;
         bcd    <= '0;
         neg    <= 1'b0;
         idx    <= '0;
         cnt    <= '0;
      end else begin
         DROP <= (SEL == 3'b010) && (state != IDLE);
         if (SEL == 3'b001) ALU_A  <= data_in;
         if (SEL == 3'b100) ALU_OP <= data_in;
         case (state)
            IDLE: begin
               if (SEL == 3'b010) begin
                  ALU_B <= data_in;
                  state <= CALC;
               end
            end
            CALC: begin
               neg   <= SIGNED && ALU_RES[NBIT-1];
               bin   <= mag;
               bcd   <= '0;
               cnt   <= '0;
               state <= CONV;
            end
            CONV: begin
               bcd <= bcd_nxt;
               bin <= bin << 1;
               cnt <= cnt + 5'd1;
               if (cnt == 5'(NBIT-1)) begin
                  idx   <= lead(bcd_nxt);
                  state <= neg ? SIGN : DIGITS;
               end
            end
            SIGN: if (WR_FIFO) state <= DIGITS;
            DIGITS: begin
               if (WR_FIFO) begin
                  if (idx == 3'd0) state <= CR;
                  else             idx   <= idx - 3'd1;
               end
            end
            CR: if (WR_FIFO) state <= LF;
            LF: if (WR_FIFO) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_tx_sequencer.sv
// Scoreboard bench: a signed and an unsigned instance share stimulus; the expected character streams are queued at start.
module tb_alu_tx_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] data_in;
   logic [2:0] sel;
   logic [7:0] alu_res;
   logic       fifo_full;

   logic [7:0] a_s, b_s, op_s, tx_s, a_u, b_u, op_u, tx_u;
   logic       wr_s, busy_s, drop_s, wr_u, busy_u, drop_u;

   logic [7:0] exp_s[$];
   logic [7:0] exp_u[$];
   int         pass_cnt = 0;
   int         total_cnt = 0;
   int         n;

   always #5 clk = ~clk;

   alu_tx_sequencer #(.NBIT(8), .SIGNED(1'b1)) dut_s (
      .CLK(clk), .RESET(reset), .data_in(data_in), .SEL(sel),
      .ALU_A(a_s), .ALU_B(b_s), .ALU_OP(op_s), .ALU_RES(alu_res),
      .FIFO_full(fifo_full), .WR_FIFO(wr_s), .tx_data(tx_s),
      .BUSY(busy_s), .DROP(drop_s));

   alu_tx_sequencer #(.NBIT(8), .SIGNED(1'b0)) dut_u (
      .CLK(clk), .RESET(reset), .data_in(data_in), .SEL(sel),
      .ALU_A(a_u), .ALU_B(b_u), .ALU_OP(op_u), .ALU_RES(alu_res),
      .FIFO_full(fifo_full), .WR_FIFO(wr_u), .tx_data(tx_u),
      .BUSY(busy_u), .DROP(drop_u));

   task automatic check(input string name, input int act, input int exp);
      total_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // Monitor: every write must match the head of its instance's expected stream.
   always @(negedge clk) begin
      if (wr_s) begin
         if (exp_s.size() == 0) check("signed_extra_write", int'(tx_s), -1);
         else check("signed_char", int'(tx_s), int'(exp_s.pop_front()));
      end
      if (wr_u) begin
         if (exp_u.size() == 0) check("unsigned_extra_write", int'(tx_u), -1);
         else check("unsigned_char", int'(tx_u), int'(exp_u.pop_front()));
      end
   end

   task automatic push_exp(input logic [7:0] r);
      string ss, su;
      ss = $sformatf("%0d", $signed(r));
      su = $sformatf("%0d", r);
      for (int i = 0; i < ss.len(); i++) exp_s.push_back(ss[i]);
      for (int i = 0; i < su.len(); i++) exp_u.push_back(su[i]);
      exp_s.push_back(8'h0D); exp_s.push_back(8'h0A);
      exp_u.push_back(8'h0D); exp_u.push_back(8'h0A);
   endtask

   // Called #1 after a rising edge; returns #1 after the edge that sampled the strobe.
   task automatic load(input logic [2:0] s, input logic [7:0] v);
      sel = s;
      data_in = v;
      @(posedge clk); #1;
      sel = 3'b000;
   endtask

   task automatic start_txn(input logic [7:0] a, input logic [7:0] op,
                            input logic [7:0] b, input logic [7:0] r);
      alu_res = r;
      load(3'b001, a);
      load(3'b100, op);
      push_exp(r);
      load(3'b010, b);
   endtask

   task automatic wait_first(output int cyc);
      cyc = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         cyc++;
         if (wr_s) break;
      end
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 100; i++) begin
         if (!busy_s && !busy_u) break;
         @(posedge clk); #1;
      end
      check("idle_reached", int'(busy_s || busy_u), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0; sel = 3'b000; data_in = 8'h00; alu_res = 8'h00; fifo_full = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_alu_a", int'(a_s), 0);
      check("rst_alu_b", int'(b_s), 0);
      check("rst_alu_op", int'(op_s), 32'h20);
      check("rst_wr", int'(wr_s), 0);
      check("rst_tx", int'(tx_s), 0);
      check("rst_busy", int'(busy_s), 0);
      check("rst_drop", int'(drop_s), 0);
      reset = 1'b1;
      @(posedge clk); #1;

      // 5 + 3 = 8: latency and BUSY around the LF write
      start_txn(8'd5, 8'h20, 8'd3, 8'd8);
      check("load_a", int'(a_s), 5);
      check("load_op", int'(op_s), 32'h20);
      check("load_b", int'(b_s), 3);
      check("busy_calc", int'(busy_s), 1);
      wait_first(n);
      check("first_write_latency", n, 9);
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("lf_wr", int'(wr_s), 1);
      check("lf_busy", int'(busy_s), 1);
      @(posedge clk); #1;
      check("busy_after_lf", int'(busy_s), 0);
      check("wr_after_lf", int'(wr_s), 0);

      start_txn(8'd1, 8'h20, 8'd2, 8'hFE);
      wait_idle();
      start_txn(8'd1, 8'h20, 8'd2, 8'h80);
      wait_idle();
      start_txn(8'd1, 8'h20, 8'd2, 8'h00);
      wait_idle();

      // 127 with the FIFO full for three cycles from the second character
      start_txn(8'd100, 8'h20, 8'd27, 8'd127);
      wait_first(n);
      @(posedge clk); #1;
      fifo_full = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("stall_wr", int'(wr_s), 0);
         check("stall_tx", int'(tx_s), 32'h32);
         check("stall_wr_u", int'(wr_u), 0);
         @(posedge clk); #1;
      end
      fifo_full = 1'b0;
      #1;
      check("resume_wr", int'(wr_s), 1);
      check("resume_tx", int'(tx_s), 32'h32);
      wait_idle();

      // Strobes while in DIGITS
      start_txn(8'd5, 8'h20, 8'd3, 8'd100);
      wait_first(n);
      load(3'b001, 8'd9);
      check("a_update_busy", int'(a_s), 9);
      load(3'b010, 8'd77);
      check("drop_pulse", int'(drop_s), 1);
      check("b_unchanged", int'(b_s), 3);
      @(posedge clk); #1;
      check("drop_one_cycle", int'(drop_s), 0);
      wait_idle();

      // Reset in DIGITS discards the rest of the stream
      start_txn(8'd5, 8'h20, 8'd3, 8'd100);
      wait_first(n);
      @(negedge clk); #1;
      reset = 1'b0;
      #1;
      check("arst_wr_s", int'(wr_s), 0);
      check("arst_wr_u", int'(wr_u), 0);
      check("arst_alu_a", int'(a_s), 0);
      check("arst_alu_b", int'(b_s), 0);
      check("arst_alu_op", int'(op_s), 32'h20);
      check("arst_tx", int'(tx_s), 0);
      check("arst_busy", int'(busy_s), 0);
      check("arst_drop", int'(drop_s), 0);
      exp_s.delete();
      exp_u.delete();
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      start_txn(8'd1, 8'h20, 8'd6, 8'd7);
      wait_idle();

      repeat (3) @(posedge clk);
      #1;
      check("signed_stream_drained", exp_s.size(), 0);
      check("unsigned_stream_drained", exp_u.size(), 0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
